// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int REQ_CORE = 0;
   localparam int REQ_HK   = 1;

   localparam int DEF_NUM_WMASKS = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 9;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      if (req == 2'b11) grant = ~last_grant;
      else              grant = req[1];
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between the management core and the housekeeping engine,
// registering the command and steering a one-cycle ack plus read data back.
import sram_arb_pkg::*;

module sram_port_arbiter #(
   parameter int NUM_WMASKS = DEF_NUM_WMASKS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req_i,
   input  logic [1:0]              we_i,
   input  logic [2*NUM_WMASKS-1:0] wmask_i,
   input  logic [2*ADDR_WIDTH-1:0] addr_i,
   input  logic [2*DATA_WIDTH-1:0] wdata_i,
   output logic [1:0]              ack_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    csb0,
   output logic                    web0,
   output logic [NUM_WMASKS-1:0]   wmask0,
   output logic [ADDR_WIDTH-1:0]   addr0,
   output logic [DATA_WIDTH-1:0]   din0,
   input  logic [DATA_WIDTH-1:0]   dout0
);

   state_e                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    csb0_q, csb0_d;
   logic                    web0_q, web0_d;
   logic [NUM_WMASKS-1:0]   wmask0_q, wmask0_d;
   logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
   logic [DATA_WIDTH-1:0]   din0_q, din0_d;
   logic [1:0]              ack_q, ack_d;

   logic [1:0] arb_req;
   logic       grant;
   logic       any_req;

   // last_grant doubles as the in-flight winner: it is loaded together with the command.
   always_comb begin
      arb_req = 2'b00;
      case (state_q)
         IDLE:    arb_req = req_i;
         RESP:    arb_req = req_i & (last_grant_q ? 2'b01 : 2'b10);
         default: arb_req = 2'b00;
      endcase
   end

   rr_arbiter_2 u_rr (
      .req        (arb_req),
      .last_grant (last_grant_q),
      .grant      (grant),
      .any_req    (any_req)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      csb0_d       = 1'b1;
      web0_d       = web0_q;
      wmask0_d     = wmask0_q;
      addr0_d      = addr0_q;
      din0_d       = din0_q;
      ack_d        = 2'b00;
      case (state_q)
         CMD: begin
            state_d          = RESP;
            ack_d[REQ_CORE]  = ~last_grant_q;
            ack_d[REQ_HK]    = last_grant_q;
         end
         default: begin
            if (any_req) begin
               state_d      = CMD;
               last_grant_d = grant;
               csb0_d       = 1'b0;
               web0_d       = ~we_i[grant];
               wmask0_d     = grant ? wmask_i[NUM_WMASKS +: NUM_WMASKS] : wmask_i[0 +: NUM_WMASKS];
               addr0_d      = grant ? addr_i[ADDR_WIDTH +: ADDR_WIDTH]   : addr_i[0 +: ADDR_WIDTH];
               din0_d       = grant ? wdata_i[DATA_WIDTH +: DATA_WIDTH]  : wdata_i[0 +: DATA_WIDTH];
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         csb0_q       <= 1'b1;
         web0_q       <= 1'b1;
         wmask0_q     <= '0;
         addr0_q      <= '0;
         din0_q       <= '0;
         ack_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         csb0_q       <= csb0_d;
         web0_q       <= web0_d;
         wmask0_q     <= wmask0_d;
         addr0_q      <= addr0_d;
         din0_q       <= din0_d;
         ack_q        <= ack_d;
      end
   end

   assign ack_o  = ack_q;
   assign csb0   = csb0_q;
   assign web0   = web0_q;
   assign wmask0 = wmask0_q;
   assign addr0  = addr0_q;
   assign din0   = din0_q;

   // The command registers still hold the acked access during RESP, so web0 tells read from write.
   assign rdata_o = ((|ack_q) && web0_q) ? dout0 : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural 512x32 SRAM on port 0.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_i = '0;
   logic [1:0]  we_i = '0;
   logic [7:0]  wmask_i = '0;
   logic [17:0] addr_i = '0;
   logic [63:0] wdata_i = '0;
   logic [1:0]  ack_o;
   logic [31:0] rdata_o;
   logic        csb0, web0;
   logic [3:0]  wmask0;
   logic [8:0]  addr0;
   logic [31:0] din0;
   logic [31:0] dout0 = '0;

   logic [31:0] mem [0:511];

   sram_port_arbiter #(.NUM_WMASKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .wmask_i(wmask_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!csb0) begin
         if (!web0) begin
            for (int b = 0; b < 4; b++)
               if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
         end else begin
            dout0 <= mem[addr0];
         end
      end
   end

   typedef struct {
      logic [1:0]  ack;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];

   int   total = 0;
   int   bad = 0;
   int   csb_lo = 0;
   logic csb_prev = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (!csb0) begin
               csb_lo++;
               check("csb0_single_cycle", {31'b0, csb_prev}, 32'd1);
            end
            if (ack_o != 2'b00) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_ack: got ack=%b with empty scoreboard", ack_o);
               end else begin
                  e = sb.pop_front();
                  check("ack_vector", {30'b0, ack_o}, {30'b0, e.ack});
                  check("rdata", rdata_o, e.rdata);
               end
            end else begin
               check("rdata_zero_no_ack", rdata_o, 32'h0);
            end
         end
         csb_prev = csb0;
      end
   endtask

   task automatic wait_ack(input int r, output int t);
      t = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ack_o[r]) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         total++;
         bad++;
         $display("FAIL ack_timeout: no ack for requester %0d, want one within 12 cycles", r);
         t = 0;
      end
   endtask

   task automatic drive(input int r, input bit we, input logic [3:0] m,
                        input logic [8:0] a, input logic [31:0] d);
      we_i[r]          = we;
      wmask_i[r*4 +: 4] = m;
      addr_i[r*9 +: 9]  = a;
      wdata_i[r*32 +: 32] = d;
      req_i[r]         = 1'b1;
   endtask

   task automatic access(input int r, input bit we, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      int t0, t;
      @(posedge clk); #1;
      drive(r, we, m, a, d);
      sb.push_back('{ack: (r == 1) ? 2'b10 : 2'b01, rdata: exp_rd});
      t0 = cyc;
      wait_ack(r, t);
      check("ack_latency", t - t0, 32'd2);
      @(posedge clk); #1;
      req_i[r] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, ta, tb, tc, td, n0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_csb0",   {31'b0, csb0}, 32'd1);
      check("rst_web0",   {31'b0, web0}, 32'd1);
      check("rst_wmask0", {28'b0, wmask0}, 32'd0);
      check("rst_addr0",  {23'b0, addr0}, 32'd0);
      check("rst_din0",   din0, 32'd0);
      check("rst_ack",    {30'b0, ack_o}, 32'd0);
      check("rst_rdata",  rdata_o, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // preload through the DUT with full-mask writes
      access(0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF, 32'h0);
      access(1, 1'b1, 4'hF, 9'h1FF, 32'hAAAAAAAA, 32'h0);
      access(0, 1'b1, 4'hF, 9'h003, 32'h12345678, 32'h0);
      access(0, 1'b1, 4'hF, 9'h010, 32'h10101010, 32'h0);
      access(1, 1'b1, 4'hF, 9'h020, 32'h20202020, 32'h0);

      // single read with command-phase checks
      @(posedge clk); #1;
      drive(0, 1'b0, 4'h0, 9'h005, 32'h0);
      sb.push_back('{ack: 2'b01, rdata: 32'hDEADBEEF});
      t0 = cyc;
      @(negedge clk);
      @(negedge clk);
      check("read_csb0_low", {31'b0, csb0}, 32'd0);
      check("read_web0",     {31'b0, web0}, 32'd1);
      check("read_addr0",    {23'b0, addr0}, 32'h005);
      wait_ack(0, ta);
      check("read_latency", ta - t0, 32'd2);
      @(posedge clk); #1;
      req_i[0] = 1'b0;

      // masked write then readback
      access(1, 1'b1, 4'b0101, 9'h1FF, 32'h11223344, 32'h0);
      access(1, 1'b0, 4'h0,    9'h1FF, 32'h0,        32'hAA22AA44);

      // zero-mask write changes nothing
      access(0, 1'b1, 4'h0, 9'h003, 32'hFFFFFFFF, 32'h0);
      access(0, 1'b0, 4'h0, 9'h003, 32'h0,        32'h12345678);

      // request dropped right after grant still completes exactly once
      @(posedge clk); #1;
      n0 = csb_lo;
      drive(0, 1'b1, 4'hF, 9'h030, 32'hCAFEF00D);
      sb.push_back('{ack: 2'b01, rdata: 32'h0});
      @(negedge clk);
      @(negedge clk); #1;
      req_i[0] = 1'b0;
      wait_ack(0, ta);
      repeat (5) @(negedge clk);
      check("drop_single_access", csb_lo - n0, 32'd1);
      access(0, 1'b0, 4'h0, 9'h030, 32'h0, 32'hCAFEF00D);

      // reset while the command is on the port: access is lost
      @(posedge clk); #1;
      drive(0, 1'b0, 4'h0, 9'h005, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("cmd_before_reset", {31'b0, csb0}, 32'd0);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_mid_csb0", {31'b0, csb0}, 32'd1);
      check("rst_mid_ack",  {30'b0, ack_o}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      req_i = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_mid_no_ack_pending", sb.size(), 32'd0);

      // held tie after reset: 0,1,0,1 back to back
      @(posedge clk); #1;
      drive(0, 1'b0, 4'h0, 9'h010, 32'h0);
      drive(1, 1'b0, 4'h0, 9'h020, 32'h0);
      sb.push_back('{ack: 2'b01, rdata: 32'h10101010});
      sb.push_back('{ack: 2'b10, rdata: 32'h20202020});
      sb.push_back('{ack: 2'b01, rdata: 32'h10101010});
      sb.push_back('{ack: 2'b10, rdata: 32'h20202020});
      t0 = cyc;
      wait_ack(0, ta);
      check("tie_first_latency", ta - t0, 32'd2);
      wait_ack(1, tb);
      check("tie_gap_1", tb - ta, 32'd2);
      wait_ack(0, tc);
      #1 req_i[0] = 1'b0;
      check("tie_gap_2", tc - tb, 32'd2);
      wait_ack(1, td);
      #1 req_i[1] = 1'b0;
      check("tie_gap_3", td - tc, 32'd2);
      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
